// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
// Optional signed-overflow flag enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] acc_shift;

  // One digit of the ripple: LSB digit of each operand plus the running carry.
  always_comb begin
    {dig_cout, dig_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry_q};
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_shift;
          cout_d  = dig_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic msb_cin;
  logic ovf_q, ovf_d;

  // Carry into the MSB recovered from the MSB's operand bits and its sum bit.
  always_comb begin
    msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];
    ovf_d   = ovf_q;
    if (state_q == RUN && cnt_q == LAST) ovf_d = msb_cin ^ dig_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL take parameter DIGIT, default 2, meaning bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new operation.
REQ-007 sub  input  1  0 = add, 1 = subtract (A - B).
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in for add; ignored when sub=1.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out; for subtract, 1 means no borrow.
REQ-015 ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 In IDLE or DONE with start=1 at a rising edge, the block SHALL capture a, b and sub, clear the digit counter, and go to RUN.
  - Initial carry: cin for add, 1 for subtract.
REQ-018 While sub=1, the operand B SHALL be bitwise-inverted at capture, giving A + ~B + 1.
REQ-019 Each RUN cycle SHALL add the least-significant DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT-bit result is shifted into sum from the MSB side.
  - The carry register takes the digit carry-out.
  - The A and B registers shift right by DIGIT.
REQ-020 After N = WIDTH/DIGIT RUN cycles, the FSM SHALL enter DONE.
  - done=1 for exactly one cycle; busy=0 from that edge.
  - Latency: start sampled at edge k, done high in the cycle after edge k+N.
REQ-021 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-022 start while in RUN SHALL be ignored, with no effect on the operands or the counter.
REQ-023 start in DONE SHALL be accepted: done still pulses that cycle, and RUN begins at the next edge.
REQ-024 sum, cout and ovf SHALL hold their last result until the next DONE.
  - They are not guaranteed valid during RUN (sum shifts).
REQ-025 Inputs a, b, sub and cin SHALL be sampled only at start acceptance; later changes have no effect.
REQ-026 The result SHALL be exact modulo 2^WIDTH; cout SHALL be bit WIDTH of the full sum.

Reset
REQ-027 rst_n=0 SHALL immediately force:
  - FSM to IDLE, counter to 0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Carry and operand registers to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After reset release, the first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Configuration
REQ-030 Macro DIGIT_SERIAL_ADDER_OVF_EN SHALL control overflow detection.
  - Defined: ovf = carry into MSB XOR carry out of MSB of the final digit, registered at DONE.
  - Undefined: the ovf port SHALL remain present and tied to 0, with no overflow logic synthesized.

Verification
REQ-031 WIDTH=8, DIGIT=2, add: a=0xFF, b=0x01, cin=0 -> done 4 cycles after start, sum=0x00, cout=1, busy high 4 cycles.
REQ-032 Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-033 With OVF_EN: add 0x7F+0x01 -> sum=0x80, ovf=1; add 0x80+0xFF -> sum=0x7F, cout=1, ovf=1; without OVF_EN both give ovf=0.
REQ-034 start re-pulsed at cycles 1-3 of RUN with new operands -> ignored, first result unchanged; start in the DONE cycle -> back-to-back result after 4 more cycles.
REQ-035 rst_n pulsed low at RUN cycle 2 -> all outputs 0 at once, no done pulse; next start computes correctly.
REQ-036 Sweep WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8 (N=1) with random operands -> sum/cout match the reference model; done exactly N cycles after start.
